// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory-port arbiter: address type, FSM state encoding
// and the hold counter width.
package mem_port_arbiter_pkg;

  localparam int HOLD_CNT_W = 16;

  typedef logic [31:0] addr_t;

  typedef enum logic {
    ARB_IDLE,
    ARB_OWN
  } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester at or after ptr (wrapping),
// skipping any proc flagged in excl.
module mem_port_arbiter_rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  logic [N-1:0]     excl,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  logic [N-1:0] cand;

  assign cand = req & ~excl;

  // Last assignment wins: the wrapped region (below ptr) is scanned first so the
  // lowest candidate at/after ptr overrides it when one exists.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (cand[k] && (IDX_W'(k) < ptr)) begin
        valid = 1'b1;
        idx   = IDX_W'(k);
      end
    end
    for (int k = N - 1; k >= 0; k--) begin
      if (cand[k] && (IDX_W'(k) >= ptr)) begin
        valid = 1'b1;
        idx   = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Ownership-locked round-robin arbiter for the shared memory port: the owner keeps
// the port while it requests, with fair-share preemption only on a write cycle.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter  int N_PROC   = 4,
  parameter  int ADDR_W   = 32,
  parameter  int DATA_W   = 128,
  parameter  int MAX_HOLD = 16,
  localparam int OWN_W    = $clog2(N_PROC)
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  input  logic [N_PROC-1:0]    i_req_rd,
  input  logic [N_PROC-1:0]    i_req_wr,
  input  logic [N_PROC*ADDR_W-1:0] i_addr,
  input  logic [N_PROC*DATA_W-1:0] i_wdata,
  input  logic [N_PROC*2-1:0]  i_wr_size,
  output logic [N_PROC-1:0]    o_grant_rd,
  output logic [N_PROC-1:0]    o_grant_wr,
  output logic [DATA_W-1:0]    o_rdata,
  output logic [ADDR_W-1:0]    o_mem_addr,
  output logic [DATA_W-1:0]    o_mem_wdata,
  output logic [1:0]           o_mem_wr_size,
  output logic                 o_mem_re,
  output logic                 o_mem_we,
  input  logic [DATA_W-1:0]    i_mem_rdata,
  output logic [OWN_W-1:0]     o_owner,
  output logic                 o_busy,
  output logic                 o_hold_err
);

  localparam logic [31:0] MAX_HOLD_U = 32'(MAX_HOLD);
  localparam logic [31:0] ERR_LIM_U  = 32'(4 * MAX_HOLD);

  arb_state_t             state_reg, state_next;
  logic [OWN_W-1:0]       owner_reg, owner_next;
  logic [OWN_W-1:0]       rr_ptr_reg, rr_ptr_next;
  logic [HOLD_CNT_W-1:0]  hold_cnt_reg, hold_cnt_next;
  logic                   hold_err_reg, hold_err_next;

  logic [N_PROC-1:0]      req;
  logic [N_PROC-1:0]      owner_oh;
  logic [N_PROC-1:0]      pick_excl;
  logic [OWN_W-1:0]       owner_inc;
  logic [OWN_W-1:0]       pick_ptr;
  logic [OWN_W-1:0]       pick_idx;
  logic                   pick_valid;
  logic                   busy;
  logic                   owner_req;
  logic                   other_req;
  logic                   preempt;
  logic                   release_own;

  assign req  = i_req_rd | i_req_wr;
  assign busy = (state_reg == ARB_OWN);

  // Read wins over write for the owner so FETCH never loses its grant to a write.
  generate
    for (genvar gi = 0; gi < N_PROC; gi++) begin : g_grant
      assign owner_oh[gi]   = (owner_reg == OWN_W'(gi));
      assign o_grant_rd[gi] = busy & owner_oh[gi] & i_req_rd[gi];
      assign o_grant_wr[gi] = busy & owner_oh[gi] & i_req_wr[gi] & ~i_req_rd[gi];
    end
  endgenerate

  assign owner_req = |(req & owner_oh);
  assign other_req = |(req & ~owner_oh);
  assign owner_inc = (owner_reg == OWN_W'(N_PROC - 1)) ? '0 : owner_reg + OWN_W'(1);

  assign preempt     = (MAX_HOLD != 0) && (32'(hold_cnt_reg) >= MAX_HOLD_U) &&
                       (|o_grant_wr) && other_req;
  assign release_own = busy && (!owner_req || preempt);

  // While owning, the same picker chooses the successor starting after the owner.
  assign pick_ptr  = busy ? owner_inc : rr_ptr_reg;
  assign pick_excl = busy ? owner_oh : '0;

  mem_port_arbiter_rr_pick #(
    .N     (N_PROC),
    .IDX_W (OWN_W)
  ) u_rr_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .excl  (pick_excl),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    state_next    = state_reg;
    owner_next    = owner_reg;
    rr_ptr_next   = rr_ptr_reg;
    hold_cnt_next = hold_cnt_reg;
    unique case (state_reg)
      ARB_IDLE: begin
        if (pick_valid) begin
          state_next    = ARB_OWN;
          owner_next    = pick_idx;
          hold_cnt_next = '0;
        end
      end
      ARB_OWN: begin
        if (release_own) begin
          rr_ptr_next   = owner_inc;
          hold_cnt_next = '0;
          if (pick_valid) begin
            owner_next = pick_idx;
          end else begin
            state_next = ARB_IDLE;
          end
        end else if (hold_cnt_reg != '1) begin
          hold_cnt_next = hold_cnt_reg + HOLD_CNT_W'(1);
        end
      end
      default: begin
        state_next = ARB_IDLE;
      end
    endcase
    hold_err_next = hold_err_reg |
                    ((MAX_HOLD != 0) && (32'(hold_cnt_next) >= ERR_LIM_U));
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_reg    <= ARB_IDLE;
      owner_reg    <= '0;
      rr_ptr_reg   <= '0;
      hold_cnt_reg <= '0;
      hold_err_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      owner_reg    <= owner_next;
      rr_ptr_reg   <= rr_ptr_next;
      hold_cnt_reg <= hold_cnt_next;
      hold_err_reg <= hold_err_next;
    end
  end

  always_comb begin
    o_mem_addr    = '0;
    o_mem_wdata   = '0;
    o_mem_wr_size = '0;
    if (busy) begin
      o_mem_addr    = i_addr[owner_reg*ADDR_W +: ADDR_W];
      o_mem_wdata   = i_wdata[owner_reg*DATA_W +: DATA_W];
      o_mem_wr_size = i_wr_size[owner_reg*2 +: 2];
    end
  end

  assign o_mem_re   = |o_grant_rd;
  assign o_mem_we   = |o_grant_wr;
  assign o_rdata    = i_mem_rdata;
  assign o_owner    = owner_reg;
  assign o_busy     = busy;
  assign o_hold_err = hold_err_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios plus randomized traffic for mem_port_arbiter, checked every cycle
// against a rule-level model of ownership, round-robin order and preemption.
module tb_mem_port_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 128;
  localparam int MH = 4;

  logic             clk  = 1'b0;
  logic             rstn = 1'b0;
  logic [N-1:0]     req_rd = '0;
  logic [N-1:0]     req_wr = '0;
  logic [N*AW-1:0]  addr = '0;
  logic [N*DW-1:0]  wdata = '0;
  logic [N*2-1:0]   wr_size = '0;
  logic [DW-1:0]    mem_rdata = '0;

  logic [N-1:0]     grant_rd, grant_wr;
  logic [DW-1:0]    rdata, mem_wdata;
  logic [AW-1:0]    mem_addr;
  logic [1:0]       mem_wr_size;
  logic             mem_re, mem_we, busy, hold_err;
  logic [1:0]       owner;

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the port, where the round-robin resumes, how long held.
  bit m_busy;
  int m_owner;
  int m_ptr;
  int m_held;
  bit m_err;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .N_PROC   (N),
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .MAX_HOLD (MH)
  ) dut (
    .i_clk         (clk),
    .i_rstn        (rstn),
    .i_req_rd      (req_rd),
    .i_req_wr      (req_wr),
    .i_addr        (addr),
    .i_wdata       (wdata),
    .i_wr_size     (wr_size),
    .o_grant_rd    (grant_rd),
    .o_grant_wr    (grant_wr),
    .o_rdata       (rdata),
    .o_mem_addr    (mem_addr),
    .o_mem_wdata   (mem_wdata),
    .o_mem_wr_size (mem_wr_size),
    .o_mem_re      (mem_re),
    .o_mem_we      (mem_we),
    .i_mem_rdata   (mem_rdata),
    .o_owner       (owner),
    .o_busy        (busy),
    .o_hold_err    (hold_err)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int first_from(input int start, input logic [N-1:0] r, input int skip);
    for (int k = 0; k < N; k++) begin
      int p;
      p = (start + k) % N;
      if (r[p] && p != skip) return p;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_ptr   = 0;
    m_held  = 0;
    m_err   = 1'b0;
  endtask

  // Advance the model across one rising edge using the inputs currently applied.
  task automatic model_step();
    logic [N-1:0] r;
    int  p;
    bit  others;
    bit  wr_cycle;
    r = req_rd | req_wr;
    if (!m_busy) begin
      p = first_from(m_ptr, r, -1);
      if (p >= 0) begin
        m_busy  = 1'b1;
        m_owner = p;
        m_held  = 0;
      end
    end else begin
      others = 1'b0;
      for (int k = 0; k < N; k++) if (k != m_owner && r[k]) others = 1'b1;
      wr_cycle = req_wr[m_owner] && !req_rd[m_owner];
      if (!r[m_owner] || (MH != 0 && m_held >= MH && wr_cycle && others)) begin
        m_ptr  = (m_owner + 1) % N;
        m_held = 0;
        p = first_from(m_ptr, r, m_owner);
        if (p >= 0) m_owner = p;
        else m_busy = 1'b0;
      end else begin
        if (m_held < 65535) m_held++;
        if (MH != 0 && m_held >= 4 * MH) m_err = 1'b1;
      end
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0]  e_rd, e_wr;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    logic [1:0]    e_sz;
    e_rd = '0; e_wr = '0; e_addr = '0; e_wd = '0; e_sz = '0;
    if (m_busy) begin
      e_rd[m_owner] = req_rd[m_owner];
      e_wr[m_owner] = req_wr[m_owner] & ~req_rd[m_owner];
      e_addr = addr[m_owner*AW +: AW];
      e_wd   = wdata[m_owner*DW +: DW];
      e_sz   = wr_size[m_owner*2 +: 2];
      chk("owner", 128'(owner), 128'(m_owner));
    end
    chk("grant_rd", 128'(grant_rd), 128'(e_rd));
    chk("grant_wr", 128'(grant_wr), 128'(e_wr));
    chk("mem_re", 128'(mem_re), 128'(|e_rd));
    chk("mem_we", 128'(mem_we), 128'(|e_wr));
    chk("busy", 128'(busy), 128'(m_busy));
    chk("mem_addr", 128'(mem_addr), 128'(e_addr));
    chk("mem_wdata", mem_wdata, e_wd);
    chk("mem_wr_size", 128'(mem_wr_size), 128'(e_sz));
    chk("rdata", rdata, mem_rdata);
    chk("hold_err", 128'(hold_err), 128'(m_err));
  endtask

  task automatic cyc(input logic [N-1:0] rd_v, input logic [N-1:0] wr_v);
    @(negedge clk);
    req_rd = rd_v;
    req_wr = wr_v;
    for (int k = 0; k < N * AW / 32; k++) addr[k*32 +: 32] = $urandom;
    for (int k = 0; k < N * DW / 32; k++) wdata[k*32 +: 32] = $urandom;
    for (int k = 0; k < DW / 32; k++) mem_rdata[k*32 +: 32] = $urandom;
    wr_size = 8'($urandom);
    #1;
    check_outputs();
    model_step();
  endtask

  task automatic cyc_own(input logic [N-1:0] rd_v, input logic [N-1:0] wr_v, input int exp_own);
    cyc(rd_v, wr_v);
    chk("dir_busy", 128'(busy), 128'(exp_own >= 0));
    if (exp_own >= 0) chk("dir_owner", 128'(owner), 128'(exp_own));
  endtask

  // Reset asserted mid-cycle with the given requests still held by the procs.
  task automatic apply_reset(input logic [N-1:0] rd_v, input logic [N-1:0] wr_v);
    @(negedge clk);
    rstn   = 1'b0;
    req_rd = rd_v;
    req_wr = wr_v;
    #1;
    model_reset();
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_owner", 128'(owner), 128'(0));
    chk("rst_grant_rd", 128'(grant_rd), 128'(0));
    chk("rst_grant_wr", 128'(grant_wr), 128'(0));
    chk("rst_mem_re", 128'(mem_re), 128'(0));
    chk("rst_mem_we", 128'(mem_we), 128'(0));
    chk("rst_hold_err", 128'(hold_err), 128'(0));
    chk("rst_mem_addr", 128'(mem_addr), 128'(0));
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check_outputs();
    model_step();
  endtask

  initial begin
    logic [N-1:0] rd_v, wr_v;
    int t2_own [11] = '{-1, 0, 0, 0, 1, 1, 3, 3, -1, 0, 0};
    logic [N-1:0] t2_rd [11] = '{4'b1011, 4'b1011, 4'b1011, 4'b1010, 4'b1010, 4'b1000,
                                 4'b1000, 4'b0000, 4'b1001, 4'b1001, 4'b0000};
    int t3_own [9] = '{-1, 1, 1, 1, 0, 0, 0, 1, 1};
    logic [N-1:0] t3_rd [9] = '{4'b0010, 4'b0011, 4'b0011, 4'b0001, 4'b0011, 4'b0011,
                                4'b0010, 4'b0010, 4'b0000};
    model_reset();
    apply_reset('0, '0);

    // Single proc read-read-write: one cycle grant latency, idle after.
    cyc_own(4'b0100, 4'b0000, -1);
    chk("t1_latency", 128'(grant_rd), 128'(0));
    cyc_own(4'b0100, 4'b0000, 2);
    chk("t1_grant_rd", 128'(grant_rd), 128'(4'b0100));
    cyc_own(4'b0100, 4'b0000, 2);
    cyc_own(4'b0000, 4'b0100, 2);
    chk("t1_grant_wr", 128'(grant_wr), 128'(4'b0100));
    cyc_own(4'b0000, 4'b0000, 2);
    cyc_own(4'b0000, 4'b0000, -1);

    // Three simultaneous requesters from reset: P0, P1, P3 with zero-bubble handover.
    apply_reset('0, '0);
    for (int i = 0; i < 11; i++) cyc_own(t2_rd[i], 4'b0000, t2_own[i]);

    // Non-owner waits; re-requesting former owner waits for the new one.
    for (int i = 0; i < 9; i++) cyc_own(t3_rd[i], 4'b0000, t3_own[i]);

    // Owner raising read and write together receives only the read grant.
    cyc_own(4'b0001, 4'b0001, -1);
    cyc_own(4'b0001, 4'b0001, 0);
    chk("t5_grant_wr", 128'(grant_wr), 128'(0));
    chk("t5_mem_we", 128'(mem_we), 128'(0));
    chk("t5_grant_rd", 128'(grant_rd), 128'(4'b0001));
    cyc_own(4'b0000, 4'b0000, 0);
    cyc_own(4'b0000, 4'b0000, -1);

    // Preemption: P0 loops rd,rd,wr while P2 waits; released on the sixth owned cycle.
    apply_reset('0, '0);
    cyc_own(4'b0101, 4'b0000, -1);
    for (int i = 0; i < 9; i++) begin
      rd_v = ((i % 3) < 2 ? 4'b0001 : 4'b0000) | 4'b0100;
      wr_v = ((i % 3) == 2) ? 4'b0001 : 4'b0000;
      cyc_own(rd_v, wr_v, (i <= 5) ? 0 : 2);
      if (i == 5) chk("t4_preempt_wr", 128'(grant_wr), 128'(4'b0001));
    end
    cyc_own(4'b0000, 4'b0000, 2);
    cyc_own(4'b0000, 4'b0000, -1);

    // Long read ownership with nobody waiting raises the sticky hold error.
    apply_reset('0, '0);
    cyc_own(4'b0010, 4'b0000, -1);
    for (int i = 0; i < 20; i++) begin
      cyc_own(4'b0010, 4'b0000, 1);
      chk("hold_err_edge", 128'(hold_err), 128'(i >= 16 * MH / 4));
    end
    cyc_own(4'b0000, 4'b0000, 1);
    cyc_own(4'b0000, 4'b0000, -1);

    // Reset mid-ownership of P3 while the pointer sits at 2; afterwards P1 beats P3.
    cyc_own(4'b1000, 4'b0000, -1);
    cyc_own(4'b1000, 4'b0000, 3);
    apply_reset(4'b1010, 4'b0000);
    cyc_own(4'b1010, 4'b0000, 1);
    cyc_own(4'b0000, 4'b0000, 1);
    cyc_own(4'b0000, 4'b0000, -1);

    // Randomized traffic with sticky-ish request levels and occasional resets.
    rd_v = '0;
    wr_v = '0;
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(3) == 0) begin
          rd_v[k] = 1'($urandom_range(1));
          wr_v[k] = 1'($urandom_range(1));
        end
      end
      if (n % 700 == 699) apply_reset(rd_v, wr_v);
      else cyc(rd_v, wr_v);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
